// File: rtl/rr_otf_conv_pkg.sv
// Shared definitions for the redundant-radix on-the-fly converter:
// width helpers and the control state encoding (also used by rr_mult control).
package rr_otf_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Signed digit width: one bit more than log2(radix) to hold -(radix-1)..(radix-1).
  function automatic int digit_width(input int radix);
    return $clog2(radix) + 1;
  endfunction

  function automatic int result_width(input int radix, input int n);
    return $clog2(radix) * n + 1;
  endfunction

endpackage

// File: rtl/rr_otf_conv_step.sv
// Single-digit on-the-fly update of the Q / QM pair (QM tracks Q - 1 ulp).
module rr_otf_step
  import rr_otf_conv_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int D     = 3,
  parameter int W     = 17
) (
  input  logic signed [W-1:0] q,
  input  logic signed [W-1:0] qm,
  input  logic signed [D-1:0] digit,
  output logic signed [W-1:0] q_next,
  output logic signed [W-1:0] qm_next
);

  localparam int K = $clog2(RADIX);
  localparam logic signed [W-1:0] RADIX_W    = W'(RADIX);
  localparam logic signed [W-1:0] RADIX_M1_W = W'(RADIX - 1);
  localparam logic signed [W-1:0] ONE_W      = W'(1);

  logic signed [W-1:0] d_ext;
  logic signed [W-1:0] q_sh;
  logic signed [W-1:0] qm_sh;
  logic                neg;
  logic                pos;

  assign d_ext = {{(W-D){digit[D-1]}}, digit};
  assign q_sh  = q <<< K;
  assign qm_sh = qm <<< K;
  assign neg   = digit[D-1];
  assign pos   = !digit[D-1] && (|digit);

  // Negative digits borrow from QM; the appended digit becomes RADIX+q.
  always_comb begin
    q_next  = q_sh + d_ext;
    qm_next = qm_sh + RADIX_M1_W + d_ext;
    if (neg) q_next = qm_sh + RADIX_W + d_ext;
    if (pos) qm_next = q_sh + d_ext - ONE_W;
  end

endmodule

// File: rtl/rr_otf_conv.sv
// On-the-fly converter: accumulates N signed MSDF digits into a two's-complement
// integer with no carry-propagate stage, presenting the result one cycle after the last digit.
module rr_otf_conv
  import rr_otf_conv_pkg::*;
#(
  parameter  int RADIX = 4,
  parameter  int N     = 8,
  localparam int D     = digit_width(RADIX),
  localparam int W     = result_width(RADIX, N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                din_valid,
  input  logic signed [D-1:0] din,
  output logic                din_ready,
  output logic signed [W-1:0] dout,
  output logic                dout_valid,
  output logic                busy,
  output logic                err
);

  localparam int K  = $clog2(RADIX);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0]       LAST_CNT  = CW'(N - 1);
  localparam logic [D-1:0]        MIN_DIGIT = {1'b1, {K{1'b0}}};
  localparam logic signed [W-1:0] QM_INIT   = '1;

  conv_state_t         state;
  conv_state_t         state_next;
  logic signed [W-1:0] q_reg;
  logic signed [W-1:0] qm_reg;
  logic signed [W-1:0] qm_pred;
  logic signed [W-1:0] q_next;
  logic signed [W-1:0] qm_next;
  logic [CW-1:0]       count;
  logic                accept;
  logic                last;
  logic                illegal;

  // Handshake: a digit transfers on a rising clk edge where din_valid && din_ready;
  // din_ready is high only while accumulating, and start in the same cycle drops the digit.
  assign din_ready = (state == ACCUM);
  assign busy      = (state == ACCUM);
  assign accept    = din_valid && din_ready && !start;
  assign last      = (count == LAST_CNT);
  assign illegal   = (din == MIN_DIGIT);

  // The first digit's borrow predecessor is -1 rather than the stored QM.
  assign qm_pred = (count == '0) ? QM_INIT : qm_reg;

  rr_otf_step #(
    .RADIX (RADIX),
    .D     (D),
    .W     (W)
  ) u_step (
    .q       (q_reg),
    .qm      (qm_pred),
    .digit   (din),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ACCUM;
    end else if (accept && last) begin
      state_next = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg      <= '0;
      qm_reg     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else if (start) begin
      q_reg      <= '0;
      qm_reg     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else if (accept) begin
      q_reg  <= q_next;
      qm_reg <= qm_next;
      err    <= err | illegal;
      if (last) begin
        count      <= '0;
        dout       <= q_next;
        dout_valid <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_otf_conv.sv
// Directed bench for rr_otf_conv (RADIX=4, N=4): stimulus pushes expected results,
// a negedge monitor pops them when dout_valid rises.
module tb_rr_otf_conv;

  localparam int RADIX = 4;
  localparam int N     = 4;
  localparam int D     = 3;
  localparam int W     = 9;

  logic         clk;
  logic         rst;
  logic         start;
  logic         din_valid;
  logic [D-1:0] din;
  logic         din_ready;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [W-1:0] exp_q[$];
  logic         dv_prev = 1'b0;

  rr_otf_conv #(
    .RADIX (RADIX),
    .N     (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .err        (err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // monitor: one scoreboard entry per completed conversion
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    if (dout_valid === 1'b1 && dv_prev !== 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL sb_unexpected: got result %0h, required no result", dout);
      end else begin
        exp_v = exp_q.pop_front();
        if (dout !== exp_v) begin
          n_fails++;
          $display("FAIL sb_dout: got %0h, required %0h", dout, exp_v);
        end
      end
    end
    dv_prev = dout_valid;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start     = 1'b1;
    din_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic send_digit(input int d, input int gap);
    din_valid = 1'b0;
    repeat (gap) tick();
    din       = D'(d);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic run_conv(input int d0, input int d1, input int d2, input int d3,
                          input int gap_max, input logic [W-1:0] exp_v, input string name);
    int ds[4];
    ds = '{d0, d1, d2, d3};
    exp_q.push_back(exp_v);
    do_start();
    check({name, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check({name, "_dv_early"}, 32'(dout_valid), 32'd0);
      send_digit(ds[i], int'($urandom_range(gap_max, 0)));
    end
    check({name, "_dv_latency"}, 32'(dout_valid), 32'd1);
    check({name, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_din_ready", 32'(din_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // din_valid in IDLE is ignored
    for (int i = 0; i < 3; i++) send_digit(1, 0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_dout_valid", 32'(dout_valid), 32'd0);
    check("idle_dout", 32'(dout), 32'd0);

    run_conv(1, -1, 0, 2, 0, 9'h032, "basic");
    check("basic_err", 32'(err), 32'd0);
    run_conv(-3, -3, -3, -3, 0, 9'h101, "min");
    run_conv(3, 3, 3, 3, 0, 9'h0FF, "max");

    // illegal digit: err sticky from the cycle after -4 until next start
    exp_q.push_back(9'h040);
    do_start();
    send_digit(2, 0);
    check("err_before", 32'(err), 32'd0);
    send_digit(-4, 0);
    check("err_set", 32'(err), 32'd1);
    send_digit(0, 0);
    send_digit(0, 0);
    check("err_done_dv", 32'(dout_valid), 32'd1);
    tick();
    tick();
    check("err_hold", 32'(err), 32'd1);
    do_start();
    check("err_cleared", 32'(err), 32'd0);
    check("start_clears_dv", 32'(dout_valid), 32'd0);

    // restart mid-conversion
    exp_q.push_back(9'h001);
    do_start();
    send_digit(1, 0);
    send_digit(1, 0);
    do_start();
    for (int i = 0; i < 4; i++) send_digit((i == 3) ? 1 : 0, 0);
    check("restart_dv", 32'(dout_valid), 32'd1);

    // digit together with start is dropped
    exp_q.push_back(9'h040);
    do_start();
    send_digit(2, 0);
    start     = 1'b1;
    din_valid = 1'b1;
    din       = D'(3);
    tick();
    start     = 1'b0;
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_digit((i == 0) ? 1 : 0, 0);
    check("drop_dv", 32'(dout_valid), 32'd1);

    // reset mid-conversion
    do_start();
    send_digit(1, 0);
    send_digit(-4, 0);
    check("midrst_err_pre", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_din_ready", 32'(din_ready), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_dout_valid", 32'(dout_valid), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_over_start", 32'(busy), 32'd0);

    // gapped digits and hold in DONE
    run_conv(1, -1, 0, 2, 3, 9'h032, "gap_a");
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'(i % 2);
      din       = D'(2);
      tick();
      check("hold_dout", 32'(dout), 32'h032);
      check("hold_dv", 32'(dout_valid), 32'd1);
    end
    din_valid = 1'b0;
    run_conv(-2, 1, 3, -1, 3, 9'h19B, "gap_b");

    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rr_otf_conv.md
RR_OTF_CONV -- requirements
Module: rR_otf_conv

Interface
REQ-001 Parameter RADIX, default 4: digit radix, power of two, at least 4.
REQ-002 Parameter N, default 8: digits per operand, at least 2.
REQ-003 Derived constants:
- K = log2(RADIX).
- D = $clog2(RADIX)+1 is the digit width.
- W = K*N+1 is the result width.
REQ-004 Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
REQ-005 Ports, one per line:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a new conversion
- din_valid  in  1  digit present on din
- din  in  D  signed two's-complement MSDF digit, most significant first
- din_ready  out  1  block accepts a digit this cycle
- dout  out  W  signed two's-complement integer value of the digit string (fraction scaled by RADIX^N)
- dout_valid  out  1  dout holds a completed result
- busy  out  1  conversion in progress
- err  out  1  sticky; an out-of-range digit was accepted in the current conversion

Function
REQ-006 The legal digit set is -(RADIX-1)..(RADIX-1), the maximally redundant set produced by the rRp datapath; din = -RADIX is illegal.
REQ-007 The FSM SHALL have three states: IDLE, ACCUM, DONE.
REQ-008 FSM transitions:
- IDLE -> ACCUM on start.
- ACCUM -> DONE when the Nth digit is accepted.
- DONE -> ACCUM on start.
- No other transitions.
REQ-009 din_ready SHALL be 1 only in ACCUM; a digit is accepted when din_valid and din_ready are both 1.
REQ-010 On start, the block SHALL clear Q, QM, the digit counter and err, and deassert dout_valid the following cycle.
REQ-011 On each accepted digit q, in on-the-fly conversion:
- Q' = Q*RADIX+q if q>=0; otherwise QM*RADIX+(RADIX+q).
- QM' = Q*RADIX+(q-1) if q>0; otherwise QM*RADIX+(RADIX-1+q).
REQ-012 Q and QM SHALL be W-bit signed; the first digit uses Q=0 and QM=-1 as predecessors, so the result is exact, with no overflow, for all legal strings.
REQ-013 The digit counter SHALL count 0..N-1; acceptance at count N-1 moves to DONE.
REQ-014 dout_valid SHALL rise the cycle after the Nth digit is accepted, with dout=Q; this gives 1-cycle latency from the last digit.
REQ-015 In DONE, dout and dout_valid SHALL hold until the next start or rst.
REQ-016 start asserted in ACCUM SHALL abort the conversion and restart it; the partial result is discarded.
REQ-017 If start and an accepted digit occur in the same cycle, start wins and the digit is dropped.
REQ-018 din_valid outside ACCUM SHALL be ignored.
REQ-019 An accepted illegal digit SHALL set err and still be processed by the REQ-011 rules; err clears only on start or rst.
REQ-020 busy SHALL equal (state==ACCUM).
REQ-021 dout SHALL change only on the transition into DONE, on start, or on rst.

Reset
REQ-022 While rst is high at a clk edge, the block SHALL enter IDLE and clear:
- Q=0, QM=0, counter=0
- dout=0, dout_valid=0, err=0
REQ-023 rst mid-ACCUM SHALL discard the conversion; rst overrides start.
REQ-024 din_ready and busy SHALL be 0 the cycle after reset.

Structure
REQ-025 A shared package SHALL hold:
- the digit-width function (D from RADIX);
- the result-width function (W from RADIX and N);
- the FSM state enumeration, shared with rR_mult control.
REQ-026 One sub-module, rR_otf_step, SHALL hold the combinational single-digit Q/QM update of REQ-011; rR_otf_conv SHALL register its outputs.
REQ-027 The datapath SHALL use no multipliers; multiplication by RADIX is a shift by K.

Verification (RADIX=4, N=4, W=9)
REQ-028 Start, then digits 1,-1,0,2 on consecutive cycles -> dout=50 (9'h032), dout_valid high one cycle after the 4th digit, err=0.
REQ-029 Start, then digits -3,-3,-3,-3 -> dout=-255 (9'h101); digits 3,3,3,3 -> dout=255 (9'h0FF).
REQ-030 Start, then digits 2,-4,0,0 -> err=1 from the cycle after the -4 digit until the next start.
REQ-031 Start, digits 1,1, then start again, then 0,0,0,1 -> dout=1.
REQ-032 A digit presented together with start is dropped.
REQ-033 rst asserted after two digits -> IDLE with all outputs 0.
REQ-034 din_valid pulses in IDLE have no effect.
REQ-035 Digits with din_valid gaps of 0-3 cycles between them -> the same result as back-to-back digits; dout holds through 5 idle cycles in DONE.
